// File: rtl/gcd_job_sequencer.sv
// Job front-end for an external GCD engine: accepts one job at a time, drives the
// engine, enforces a run timeout and hands back a result with valid/ready.
module gcd_job_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [DATA_WIDTH-1:0] job_a_i,
  input  logic [DATA_WIDTH-1:0] job_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_gcd_o,
  output logic                  res_err_o,
  output logic [DATA_WIDTH-1:0] operand_a_o,
  output logic [DATA_WIDTH-1:0] operand_b_o,
  output logic                  gcd_enable_o,
  input  logic [DATA_WIDTH-1:0] gcd_i,
  input  logic                  gcd_done_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  job_count_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Handshake and enable flags are pure decodes of the state register.
  assign job_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign res_valid_o  = (state == DONE);
  assign gcd_enable_o = (state == START) || (state == RUN);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state       <= IDLE;
      timer       <= '0;
      operand_a_o <= '0;
      operand_b_o <= '0;
      res_gcd_o   <= '0;
      res_err_o   <= 1'b0;
      job_count_o <= '0;
    end else begin
      case (state)
        IDLE: if (job_valid_i) begin
          operand_a_o <= job_a_i;
          operand_b_o <= job_b_i;
          if (job_a_i == '0 || job_b_i == '0) begin
            // OR yields the nonzero operand, or 0 when both are zero.
            res_gcd_o <= job_a_i | job_b_i;
            res_err_o <= (job_a_i == '0) && (job_b_i == '0);
            state     <= DONE;
          end else begin
            state <= START;
          end
        end
        START: begin
          if (abort_i) state <= IDLE;
          else begin
            timer <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (gcd_done_i) begin
            res_gcd_o <= gcd_i;
            res_err_o <= 1'b0;
            state     <= DONE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            res_gcd_o <= '0;
            res_err_o <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: if (res_ready_i) begin
          job_count_o <= job_count_o + CNT_WIDTH'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomized bench for gcd_job_sequencer with a behavioural GCD engine and
// an Euclid reference model.
module tb_gcd_job_sequencer;
  localparam int DW = 16;
  localparam int TO = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          nreset_i = 1'b0;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  logic [DW-1:0] job_a_i = '0;
  logic [DW-1:0] job_b_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [DW-1:0] res_gcd_o;
  logic          res_err_o;
  logic [DW-1:0] operand_a_o, operand_b_o;
  logic          gcd_enable_o;
  logic [DW-1:0] gcd_i = '0;
  logic          gcd_done_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o;
  logic [CW-1:0] job_count_o;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_count = '0;
  int            eng_delay = 0;  // 0 = engine never answers
  int            en_cnt = 0;

  gcd_job_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .nreset_i(nreset_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_a_i(job_a_i), .job_b_i(job_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_gcd_o(res_gcd_o), .res_err_o(res_err_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .gcd_enable_o(gcd_enable_o), .gcd_i(gcd_i), .gcd_done_i(gcd_done_i),
    .abort_i(abort_i), .busy_o(busy_o), .job_count_o(job_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] gcd_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Engine: raises done during its eng_delay-th enabled cycle, noise otherwise.
  always @(negedge clk) begin
    if (!gcd_enable_o) begin
      en_cnt     = 0;
      gcd_done_i = 1'b0;
      gcd_i      = DW'($urandom);
    end else begin
      en_cnt     = en_cnt + 1;
      gcd_done_i = (en_cnt == eng_delay);
      gcd_i      = gcd_done_i ? gcd_ref(operand_a_o, operand_b_o) : DW'($urandom);
    end
  end

  task automatic submit(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    job_valid_i = 1'b1; job_a_i = a; job_b_i = b;
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!res_valid_o && cyc < limit) begin @(negedge clk); cyc++; end
  endtask

  task automatic take();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    exp_count = exp_count + 1'b1;
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", res_valid_o); end
    n_checks++; if (res_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", res_err_o); end
    n_checks++; if (gcd_enable_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_en_busy got %b%b want 00", gcd_enable_o, busy_o); end
    n_checks++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", job_ready_o); end
    n_checks++; if ({res_gcd_o, operand_a_o, operand_b_o} !== '0 || job_count_o !== '0) begin
      n_fail++; $display("FAIL reset_data got gcd=%0d a=%0d b=%0d cnt=%0d want 0", res_gcd_o, operand_a_o, operand_b_o, job_count_o); end
    nreset_i = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_basic();
    int cyc;
    eng_delay = 5;
    submit(16'd48, 16'd18);
    n_checks++; if (gcd_enable_o !== 1'b1) begin n_fail++; $display("FAIL basic_enable got %b want 1", gcd_enable_o); end
    n_checks++; if (operand_a_o !== 16'd48 || operand_b_o !== 16'd18) begin n_fail++; $display("FAIL basic_operands got %0d,%0d want 48,18", operand_a_o, operand_b_o); end
    wait_valid(40, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", cyc); end
    n_checks++; if (res_gcd_o !== 16'd6 || res_err_o !== 1'b0) begin n_fail++; $display("FAIL basic_result got %0d err %b want 6 err 0", res_gcd_o, res_err_o); end
    take();
    n_checks++; if (job_count_o !== exp_count) begin n_fail++; $display("FAIL basic_count got %0d want %0d", job_count_o, exp_count); end
  endtask

  task automatic test_shortcut();
    int cyc;
    logic [DW-1:0] av [2] = '{16'd0, 16'd0};
    logic [DW-1:0] bv [2] = '{16'd35, 16'd0};
    eng_delay = 3;
    for (int i = 0; i < 2; i++) begin
      submit(av[i], bv[i]);
      n_checks++; if (res_valid_o !== 1'b1 || gcd_enable_o !== 1'b0) begin n_fail++; $display("FAIL short_latency_%0d valid %b en %b want 1 0", i, res_valid_o, gcd_enable_o); end
      n_checks++; if (res_gcd_o !== bv[i] || res_err_o !== (bv[i] == 0)) begin n_fail++; $display("FAIL short_result_%0d got %0d err %b want %0d err %b", i, res_gcd_o, res_err_o, bv[i], bv[i] == 0); end
      wait_valid(5, cyc);
      take();
      n_checks++; if (gcd_enable_o !== 1'b0 || job_count_o !== exp_count) begin n_fail++; $display("FAIL short_after_%0d en %b cnt %0d want 0 %0d", i, gcd_enable_o, job_count_o, exp_count); end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    eng_delay = 0;
    submit(16'd77, 16'd21);
    wait_valid(60, cyc);
    n_checks++; if (cyc != TO + 1) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", cyc, TO + 1); end
    n_checks++; if (res_gcd_o !== '0 || res_err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_result got %0d err %b want 0 err 1", res_gcd_o, res_err_o); end
    take();
    eng_delay = TO + 1;  // done lands on the last RUN cycle
    submit(16'd77, 16'd21);
    wait_valid(60, cyc);
    n_checks++; if (cyc != TO + 1) begin n_fail++; $display("FAIL tie_latency got %0d want %0d", cyc, TO + 1); end
    n_checks++; if (res_gcd_o !== 16'd7 || res_err_o !== 1'b0) begin n_fail++; $display("FAIL tie_result got %0d err %b want 7 err 0", res_gcd_o, res_err_o); end
    take();
    n_checks++; if (job_count_o !== exp_count) begin n_fail++; $display("FAIL timeout_count got %0d want %0d", job_count_o, exp_count); end
  endtask

  task automatic test_abort();
    logic seen;
    eng_delay = 0;
    submit(16'd100, 16'd30);
    repeat (3) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++; if (gcd_enable_o !== 1'b0 || job_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_state en %b ready %b want 0 1", gcd_enable_o, job_ready_o); end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= res_valid_o; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result got valid %b want 0", seen); end
    n_checks++; if (job_count_o !== exp_count) begin n_fail++; $display("FAIL abort_count got %0d want %0d", job_count_o, exp_count); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    eng_delay = 3;
    submit(16'd84, 16'd36);
    wait_valid(40, cyc);
    job_valid_i = 1'b1; job_a_i = 16'd91; job_b_i = 16'd26;
    for (int i = 0; i < 10; i++) begin
      abort_i = (i == 4);  // ignored while holding a result
      @(negedge clk);
      n_checks++; if (res_valid_o !== 1'b1 || res_gcd_o !== 16'd12 || res_err_o !== 1'b0 || job_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d valid %b gcd %0d err %b ready %b want 1 12 0 0", i, res_valid_o, res_gcd_o, res_err_o, job_ready_o); end
    end
    abort_i = 1'b0;
    take();
    n_checks++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", job_ready_o); end
    @(negedge clk);
    job_valid_i = 1'b0;
    n_checks++; if (gcd_enable_o !== 1'b1 || operand_a_o !== 16'd91) begin n_fail++; $display("FAIL b2b_accept en %b a %0d want 1 91", gcd_enable_o, operand_a_o); end
    wait_valid(40, cyc);
    n_checks++; if (cyc != 3 || res_gcd_o !== 16'd13) begin n_fail++; $display("FAIL b2b_second lat %0d gcd %0d want 3 13", cyc, res_gcd_o); end
    take();
    n_checks++; if (job_count_o !== exp_count) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", job_count_o, exp_count); end
  endtask

  task automatic test_random();
    int cyc, d, exp_lat;
    logic [DW-1:0] a, b, eg;
    logic ee;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom_range(1, 3000));
      b = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom_range(1, 3000));
      d = $urandom_range(2, TO);
      eng_delay = d;
      if (a == 0 || b == 0) begin eg = a + b; ee = (a == 0 && b == 0); exp_lat = 0; end
      else begin eg = gcd_ref(a, b); ee = 1'b0; exp_lat = d; end
      submit(a, b);
      n_checks++; if (gcd_enable_o !== (exp_lat != 0)) begin n_fail++; $display("FAIL rand_enable_%0d got %b want %b", i, gcd_enable_o, exp_lat != 0); end
      wait_valid(40, cyc);
      n_checks++; if (cyc != exp_lat) begin n_fail++; $display("FAIL rand_latency_%0d got %0d want %0d", i, cyc, exp_lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++; if (res_valid_o !== 1'b1 || res_gcd_o !== eg || res_err_o !== ee) begin
        n_fail++; $display("FAIL rand_result_%0d a=%0d b=%0d got %0d err %b want %0d err %b", i, a, b, res_gcd_o, res_err_o, eg, ee); end
      take();
      n_checks++; if (job_count_o !== exp_count) begin n_fail++; $display("FAIL rand_count_%0d got %0d want %0d", i, job_count_o, exp_count); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    eng_delay = 0;
    submit(16'd500, 16'd125);
    repeat (3) @(negedge clk);
    #2 nreset_i = 1'b0;
    #1;
    n_checks++; if (res_valid_o !== 1'b0 || gcd_enable_o !== 1'b0 || busy_o !== 1'b0 || job_ready_o !== 1'b1 || res_err_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags valid %b en %b busy %b ready %b err %b want 0 0 0 1 0", res_valid_o, gcd_enable_o, busy_o, job_ready_o, res_err_o); end
    n_checks++; if ({res_gcd_o, operand_a_o, operand_b_o} !== '0 || job_count_o !== '0) begin
      n_fail++; $display("FAIL midreset_data gcd %0d a %0d b %0d cnt %0d want 0", res_gcd_o, operand_a_o, operand_b_o, job_count_o); end
    exp_count = '0;
    @(negedge clk);
    nreset_i = 1'b1;
    seen = 1'b0;
    repeat (TO + 4) begin @(negedge clk); seen |= res_valid_o | gcd_enable_o; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_result got activity %b want 0", seen); end
  endtask

  task automatic test_wrap();
    int seen, guard, cyc;
    res_ready_i = 1'b1; job_a_i = '0; job_b_i = 16'd7; job_valid_i = 1'b1;
    seen = 0; guard = 0;
    while (seen < 255 && guard < 2000) begin
      @(negedge clk); guard++;
      if (res_valid_o) begin
        seen++; exp_count = exp_count + 1'b1;
        if (seen == 255) job_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    res_ready_i = 1'b0;
    n_checks++; if (job_count_o !== exp_count || exp_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", job_count_o); end
    submit('0, 16'd7);
    wait_valid(5, cyc);
    take();
    n_checks++; if (job_count_o !== exp_count) begin n_fail++; $display("FAIL wrap_256 got %0d want %0d", job_count_o, exp_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shortcut();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
